// File: rtl/rr_tdm_demux.sv
// rr_tdm_demux: receive-side de-interleaver for the round-robin TDM product
// stream. Mux-side frame marker/beat-valid are delay-matched to the DSP
// latency, a HUNT/LOCKED tracker follows slot position, and each accepted
// beat lands in its channel register.
// Optional build macro RR_TDM_DEMUX_FRAME_HOLD_EN: beats collect in shadow
// registers and a whole frame is published at once on the last slot.

// Per-channel capture register (one instance per slot).
module rr_tdm_demux_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,      // beat addressed to this slot
`ifdef RR_TDM_DEMUX_FRAME_HOLD_EN
    input  logic                  i_clr,     // drop partial frame
    input  logic                  i_commit,  // publish whole frame
`endif
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

`ifdef RR_TDM_DEMUX_FRAME_HOLD_EN
    logic [DATA_WIDTH-1:0] r_shadow;

    // Shadow collects this slot's beat for the frame in progress
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
        end else if (i_wr) begin
            r_shadow <= i_data;
        end else if (i_clr) begin
            r_shadow <= '0;
        end
    end

    // Publish on commit; the last slot takes its beat straight from the bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_commit;
            if (i_commit) begin
                r_data <= i_wr ? i_data : r_shadow;
            end
        end
    end
`else
    // Capture the addressed beat and pulse valid for one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_wr;
            if (i_wr) begin
                r_data <= i_data;
            end
        end
    end
`endif

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

module rr_tdm_demux #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 2,   // must be >= 2
    parameter int ALIGN_LATENCY = 3    // 0 = markers already aligned
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame_sync,
    input  logic                    i_tdm_valid,
    input  logic [DATA_WIDTH-1:0]   i_tdm_data,
    output logic [DATA_WIDTH-1:0]   o_ch_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] o_ch_valid,
    output logic                    o_frame_done,
    output logic                    o_locked,
    output logic                    o_sync_err
);

    localparam int SW = $clog2(NUM_CHANNELS);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CHANNELS - 1);

    typedef enum logic {
        S_HUNT,
        S_LOCKED
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_slot;
    logic          r_locked;
    logic          r_sync_err;
    logic          r_frame_done;

    logic          w_d_sync;
    logic          w_d_vld;

    // ------------------------------------------------------------------
    // Marker delay lines: bring frame_sync/tdm_valid to DSP-output time
    // ------------------------------------------------------------------
    generate
        if (ALIGN_LATENCY == 0) begin : g_nodly
            assign w_d_sync = i_frame_sync;
            assign w_d_vld  = i_tdm_valid;
        end else begin : g_dly
            logic [ALIGN_LATENCY:1] r_sync_pipe;
            logic [ALIGN_LATENCY:1] r_vld_pipe;

            // Shift markers one stage per cycle; reset drops in-flight beats
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync_pipe <= '0;
                    r_vld_pipe  <= '0;
                end else begin
                    r_sync_pipe[1] <= i_frame_sync;
                    r_vld_pipe[1]  <= i_tdm_valid;
                    for (int k = 2; k <= ALIGN_LATENCY; k++) begin
                        r_sync_pipe[k] <= r_sync_pipe[k-1];
                        r_vld_pipe[k]  <= r_vld_pipe[k-1];
                    end
                end
            end

            assign w_d_sync = r_sync_pipe[ALIGN_LATENCY];
            assign w_d_vld  = r_vld_pipe[ALIGN_LATENCY];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Beat classification at the aligned point
    // ------------------------------------------------------------------
    logic          w_in_lock;
    logic          w_cap;       // beat is written somewhere
    logic [SW-1:0] w_cap_slot;  // slot it is written to
    logic          w_last;      // capture completes a frame
    logic          w_miss;      // slot 0 expected but no marker
    logic          w_resync;    // marker seen mid-frame
    logic          w_err;

    assign w_in_lock  = (r_state == S_LOCKED);
    // A marker always restarts at slot 0; otherwise only LOCKED captures
    assign w_cap      = w_d_vld & (w_d_sync | (w_in_lock & (r_slot != '0)));
    assign w_cap_slot = w_d_sync ? '0 : r_slot;
    assign w_last     = w_cap & (w_cap_slot == SLOT_LAST);
    assign w_miss     = w_d_vld & w_in_lock & ~w_d_sync & (r_slot == '0);
    assign w_resync   = w_d_vld & w_in_lock &  w_d_sync & (r_slot != '0);
    // Orphan marker (no beat) is flagged regardless of state
    assign w_err      = (w_d_sync & ~w_d_vld) | w_miss | w_resync;

    // ------------------------------------------------------------------
    // Lock tracker: state, slot counter and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_HUNT;
            r_slot       <= '0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync_err   <= w_err;
            r_frame_done <= w_last;
            if (w_d_vld) begin
                case (r_state)
                    S_HUNT: begin
                        if (w_d_sync) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                            r_slot   <= SLOT_ONE;
                        end
                    end
                    S_LOCKED: begin
                        if (w_d_sync) begin
                            r_slot <= SLOT_ONE;
                        end else if (r_slot == '0) begin
                            r_state  <= S_HUNT;
                            r_locked <= 1'b0;
                        end else if (r_slot == SLOT_LAST) begin
                            r_slot <= '0;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        r_locked <= 1'b0;
                        r_slot   <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------
`ifdef RR_TDM_DEMUX_FRAME_HOLD_EN
    logic w_flush;
    // Any new frame start or lost lock throws away the partial frame
    assign w_flush = (w_d_vld & w_d_sync) | w_miss;
`endif

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
            logic w_wr;
            assign w_wr = w_cap & (w_cap_slot == SW'(g));

            rr_tdm_demux_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_wr     (w_wr),
`ifdef RR_TDM_DEMUX_FRAME_HOLD_EN
                .i_clr    (w_flush),
                .i_commit (w_last),
`endif
                .i_data   (i_tdm_data),
                .o_data   (o_ch_data[g]),
                .o_valid  (o_ch_valid[g])
            );
        end
    endgenerate

    assign o_frame_done = r_frame_done;
    assign o_locked     = r_locked;
    assign o_sync_err   = r_sync_err;

endmodule

// File: doc/rr_tdm_demux.md
Name: rr_tdm_demux

Overview:
Receive-side counterpart of the round-robin TDM mux plus DSP multiply path. Takes the single time-multiplexed product stream coming out of the DSP and de-interleaves it back into per-channel registered outputs. The mux-side frame marker and beat-valid are delay-matched internally to the DSP pipeline latency. The block tracks slot position with a lock/hunt state machine and flags framing errors.

Parameters:
DATA_WIDTH, 16, width of each TDM beat and of each channel output (DSP product width).
NUM_CHANNELS, 2, slots per frame; must be >= 2.
ALIGN_LATENCY, 3, cycles from mux-side frame_sync/tdm_valid to the matching tdm_data at the DSP output; 0 allowed, meaning no delay.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
frame_sync  in  1  mux-side marker: high on the beat where slot 0 is selected.
tdm_valid  in  1  mux-side beat valid.
tdm_data  in  DATA_WIDTH  DSP output stream, already ALIGN_LATENCY cycles late.
ch_data  out  NUM_CHANNELS x DATA_WIDTH  registered per-channel data (unpacked array).
ch_valid  out  NUM_CHANNELS  one-cycle pulse per channel update.
frame_done  out  1  one-cycle pulse when the last slot of a frame is captured.
locked  out  1  high while in LOCKED.
sync_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - ch_data all 0, ch_valid 0, frame_done 0, sync_err 0, locked 0.
  - Delay lines cleared; slot counter 0; state HUNT.
  - Reset overrides all other inputs in the same cycle. A partial frame in progress is discarded.
- Alignment: frame_sync and tdm_valid each pass through an ALIGN_LATENCY-stage shift register, giving d_sync and d_valid. tdm_data is not delayed. A beat is "accepted" when d_valid=1.
- d_sync=1 with d_valid=0: sync_err pulses one cycle later; no state or counter change.
- State HUNT:
  - Accepted beats with d_sync=0 are ignored, with no outputs.
  - An accepted beat with d_sync=1 captures as slot 0, sets slot to 1, and moves to LOCKED.
- State LOCKED:
  - Each accepted beat is written to ch_data[slot]; slot increments and wraps from NUM_CHANNELS-1 to 0.
  - If d_sync=1 on an accepted beat while slot != 0: sync_err pulses, the beat is captured as slot 0, slot is set to 1, and the state stays LOCKED (resync).
  - If slot=0 on an accepted beat with d_sync=0 (missing marker): sync_err pulses, the beat is discarded, and the state returns to HUNT.
- d_valid=0: slot holds and no outputs change, so gaps mid-frame are legal.
- Output timing:
  - Capture from an accepted beat at cycle t makes ch_data[slot] valid at t+1, with ch_valid[slot]=1 for cycle t+1 only.
  - The slot NUM_CHANNELS-1 capture also pulses frame_done at t+1.
  - Total latency from mux-side frame_sync to ch_data[0] is ALIGN_LATENCY+1.
- locked is registered: it rises in the cycle after the HUNT to LOCKED transition and falls in the cycle after the return to HUNT.
- Unaddressed channels hold their ch_data values.
- No arithmetic on data; slot counter width is $clog2(NUM_CHANNELS).

Optional Feature:
Macro RR_TDM_DEMUX_FRAME_HOLD_EN.
- Defined:
  - Captures go to internal shadow registers.
  - On the last-slot capture, all shadows including the final beat copy to ch_data at once. ch_valid pulses all bits together with frame_done.
  - A resync or return to HUNT discards the shadow contents, and ch_data is unchanged.
- Undefined: per-slot update as described in Behaviour; no shadow registers are synthesized.

Test Plan:
1. Defaults. Reset, then from cycle 10 frame_sync=1 on even beats and tdm_valid=1 continuously. tdm_data=0x0011 at cycle 13 and 0x0022 at cycle 14 -> ch_data[0]=0x0011 with ch_valid[0] at cycle 14; ch_data[1]=0x0022 with ch_valid[1] and frame_done at cycle 15; locked=1 from cycle 14.
2. Accepted beats with 0xBEEF before any frame_sync -> no ch_valid, ch_data stays 0, locked stays 0.
3. While locked, drop tdm_valid for 2 cycles between slot 0 and slot 1 -> slot 1 still captured into ch_data[1]; frame_done only after slot 1.
4. Inject frame_sync on a slot-1 beat -> sync_err pulse; that beat's data lands in ch_data[0]; locked stays 1. Then omit frame_sync on the next slot-0 beat -> sync_err pulse, locked falls, no capture.
5. Assert rst for 1 cycle mid-frame after slot 0 -> all outputs 0 and locked 0 next cycle; resumes only on the next delayed frame_sync.
6. With RR_TDM_DEMUX_FRAME_HOLD_EN defined, repeat test 1 -> ch_data[0]=0x0011 and ch_data[1]=0x0022 both appear at cycle 15; ch_valid=2'b11 and frame_done at cycle 15; nothing at cycle 14.
